// File: rtl/core_pkg.sv
// Shared types and helpers for the RV64I multi-cycle sequencer.
// Covers state encoding, writeback-select and trap-cause codes, and byte-lane helpers.
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    TC_ILLEGAL       = 2'd0,
    TC_JMP_MISALIGN  = 2'd1,
    TC_DATA_MISALIGN = 2'd2,
    TC_DMEM_TIMEOUT  = 2'd3
  } trap_cause_t;

  // Lane mask for an access of len bytes starting at byte offset off.
  function automatic logic [7:0] byte_enables(input logic [3:0] len, input logic [2:0] off);
    logic [7:0] mask_s;
    case (len)
      4'd1:    mask_s = 8'h01;
      4'd2:    mask_s = 8'h03;
      4'd4:    mask_s = 8'h0F;
      4'd8:    mask_s = 8'hFF;
      default: mask_s = 8'h00;
    endcase
    return mask_s << off;
  endfunction

  // len_lo is the low three bits of the one-hot length; 8 bytes wraps to a 3'b111 mask.
  function automatic logic data_misaligned(input logic [2:0] len_lo, input logic [2:0] off);
    return (off & (len_lo - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/core_npc.sv
// Combinational next-PC selection: jalr target, jal/taken-branch target or pc+4.
// Also flags a target that is not 4-byte aligned.
module core_npc
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch,
  input  logic            br_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_tgt_s;

  assign jalr_tgt_s = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};

  // Select the successor PC for the instruction in EXEC.
  always_comb begin
    next_pc = pc + 64'd4;
    if (jalr) begin
      next_pc = jalr_tgt_s;
    end else if (jal || (branch && br_taken)) begin
      next_pc = pc + imm;
    end else begin
      next_pc = pc + 64'd4;
    end
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I core.
// Owns the PC, issues fetch and data requests, traps sticky on faults, counts retirements.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h8000_0000,
  parameter int          DMEM_TIMEOUT = 16,
  parameter int          TO_W         = 5
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr_q,
  input  logic            dec_illegal,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_branch,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_wb,
  input  logic [3:0]      dec_mem_len,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] alu_result,
  input  logic            br_taken,
  output logic            alu_en,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [7:0]      dmem_be,
  input  logic            dmem_ready,
  output logic            reg_wr_en,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] pc,
  output logic [63:0]     instret,
  output logic            halt,
  output logic [1:0]      trap_cause
);

  state_t          state_r;
  logic            dec_load_r;
  logic            dec_store_r;
  logic            dec_branch_r;
  logic            dec_jal_r;
  logic            dec_jalr_r;
  logic            dec_wb_r;
  logic [3:0]      dec_mem_len_r;
  logic [XLEN-1:0] next_pc_r;
  logic [TO_W-1:0] tcnt_r;
  logic [XLEN-1:0] next_pc_s;
  logic            npc_misaligned_s;
  logic            is_mem_s;

  core_npc u_npc (
    .pc         (pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .jal        (dec_jal_r),
    .jalr       (dec_jalr_r),
    .branch     (dec_branch_r),
    .br_taken   (br_taken),
    .next_pc    (next_pc_s),
    .misaligned (npc_misaligned_s)
  );

  assign is_mem_s = dec_load_r | dec_store_r;

  // Sequencer FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      instr_q       <= '0;
      alu_en        <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= 8'h00;
      reg_wr_en     <= 1'b0;
      wb_sel        <= WB_ALU;
      pc            <= RESET_PC;
      instret       <= 64'd0;
      halt          <= 1'b0;
      trap_cause    <= TC_ILLEGAL;
      dec_load_r    <= 1'b0;
      dec_store_r   <= 1'b0;
      dec_branch_r  <= 1'b0;
      dec_jal_r     <= 1'b0;
      dec_jalr_r    <= 1'b0;
      dec_wb_r      <= 1'b0;
      dec_mem_len_r <= 4'd0;
      next_pc_r     <= '0;
      tcnt_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_en) begin
            state_r   <= ST_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_FETCH: begin
          if (imem_rvalid) begin
            instr_q  <= imem_rdata;
            imem_req <= 1'b0;
            state_r  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          dec_load_r    <= dec_load;
          dec_store_r   <= dec_store;
          dec_branch_r  <= dec_branch;
          dec_jal_r     <= dec_jal;
          dec_jalr_r    <= dec_jalr;
          dec_wb_r      <= dec_wb;
          dec_mem_len_r <= dec_mem_len;
          if (dec_illegal) begin
            state_r    <= ST_TRAP;
            halt       <= 1'b1;
            trap_cause <= TC_ILLEGAL;
          end else begin
            state_r <= ST_EXEC;
            alu_en  <= 1'b1;
          end
        end
        ST_EXEC: begin
          alu_en    <= 1'b0;
          next_pc_r <= next_pc_s;
          dmem_addr <= alu_result;
          if (npc_misaligned_s) begin
            state_r    <= ST_TRAP;
            halt       <= 1'b1;
            trap_cause <= TC_JMP_MISALIGN;
          end else if (is_mem_s && data_misaligned(dec_mem_len_r[2:0], alu_result[2:0])) begin
            state_r    <= ST_TRAP;
            halt       <= 1'b1;
            trap_cause <= TC_DATA_MISALIGN;
          end else if (is_mem_s) begin
            state_r  <= ST_MEM;
            dmem_req <= 1'b1;
            dmem_we  <= dec_store_r;
            dmem_be  <= byte_enables(dec_mem_len_r, alu_result[2:0]);
            tcnt_r   <= '0;
          end else begin
            state_r   <= ST_WB;
            reg_wr_en <= dec_wb_r;
            wb_sel    <= (dec_jal_r | dec_jalr_r) ? WB_PC4 : WB_ALU;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_be   <= 8'h00;
            state_r   <= ST_WB;
            reg_wr_en <= dec_wb_r;
            wb_sel    <= dec_load_r ? WB_MEM : WB_ALU;
          end else if (tcnt_r == TO_W'(DMEM_TIMEOUT - 1)) begin
            // The cycle that brings the wait count to DMEM_TIMEOUT abandons the access.
            tcnt_r     <= tcnt_r + TO_W'(1);
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 8'h00;
            state_r    <= ST_TRAP;
            halt       <= 1'b1;
            trap_cause <= TC_DMEM_TIMEOUT;
          end else begin
            tcnt_r <= tcnt_r + TO_W'(1);
          end
        end
        ST_WB: begin
          pc        <= next_pc_r;
          instret   <= instret + 64'd1;
          reg_wr_en <= 1'b0;
          wb_sel    <= WB_ALU;
          if (run_en) begin
            state_r   <= ST_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= next_pc_r;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_TRAP: begin
          state_r <= ST_TRAP;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed scoreboard bench for core_seq_ctrl: the bench plays imem, decoder, ALU and dmem.
// Expected per-instruction outcomes are queued before each instruction and popped as it completes.
module tb_core_seq_ctrl;
  import core_pkg::*;

  localparam logic [63:0] RESET_PC     = 64'h8000_0000;
  localparam int          DMEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_q;
  logic        dec_illegal = 1'b0, dec_load = 1'b0, dec_store = 1'b0, dec_branch = 1'b0;
  logic        dec_jal = 1'b0, dec_jalr = 1'b0, dec_wb = 1'b0;
  logic [3:0]  dec_mem_len = 4'd4;
  logic [63:0] imm = 64'd0, rs1_val = 64'd0, alu_result = 64'd0;
  logic        br_taken = 1'b0;
  logic        alu_en, dmem_req, dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic        reg_wr_en;
  logic [1:0]  wb_sel;
  logic [63:0] pc, instret;
  logic        halt;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  core_seq_ctrl #(.RESET_PC(RESET_PC), .DMEM_TIMEOUT(DMEM_TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_q(instr_q), .dec_illegal(dec_illegal), .dec_load(dec_load), .dec_store(dec_store),
    .dec_branch(dec_branch), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_wb(dec_wb),
    .dec_mem_len(dec_mem_len), .imm(imm), .rs1_val(rs1_val), .alu_result(alu_result),
    .br_taken(br_taken), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_ready(dmem_ready), .reg_wr_en(reg_wr_en),
    .wb_sel(wb_sel), .pc(pc), .instret(instret), .halt(halt), .trap_cause(trap_cause)
  );

  typedef struct {
    logic [31:0] raw;
    logic        ill, ld, st, br, jl, jr, wb, taken, run_keep;
    logic [3:0]  len;
    logic [63:0] imm, rs1, alu;
    int          wait_n;
  } ins_t;

  typedef struct {
    logic [63:0] pc;
    logic        wr;
    logic [1:0]  sel;
    int          cyc, memc, aluc;
    logic [7:0]  be;
    logic        we, halt;
    logic [1:0]  cause;
    logic [63:0] daddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic ins_t blank(input logic [31:0] raw);
    ins_t i;
    i.raw = raw; i.ill = 1'b0; i.ld = 1'b0; i.st = 1'b0; i.br = 1'b0; i.jl = 1'b0;
    i.jr = 1'b0; i.wb = 1'b0; i.taken = 1'b0; i.run_keep = 1'b1; i.len = 4'd4;
    i.imm = 64'd0; i.rs1 = 64'd0; i.alu = 64'd0; i.wait_n = 0;
    return i;
  endfunction

  function automatic exp_t mkexp(input logic [63:0] p, input logic wr, input logic [1:0] sel, input int cyc);
    exp_t e;
    e.pc = p; e.wr = wr; e.sel = sel; e.cyc = cyc; e.memc = 0; e.aluc = 1; e.be = 8'h00;
    e.we = 1'b0; e.halt = 1'b0; e.cause = 2'd0; e.daddr = 64'd0;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_rvalid = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ctrl", 64'({imem_req, alu_en, dmem_req, dmem_we, reg_wr_en, halt, wb_sel, trap_cause, dmem_be}), 64'd0);
    chk("rst_addr", imem_addr | dmem_addr | instret, 64'd0);
    chk("rst_instr_q", 64'(instr_q), 64'd0);
    rst_n = 1'b1;
  endtask

  // Serve one fetch, play decoder/ALU/dmem until retirement or trap, then score against the queue.
  task automatic run_instr(input ins_t ins);
    exp_t        e;
    int          k, cyc, memc, aluc, mseen, leak, rdy_cyc, wr_cyc;
    logic        wr, we;
    logic [1:0]  sel;
    logic [7:0]  be;
    logic [63:0] start_ir, daddr;
    k = 0;
    while (!imem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", 64'(imem_req), 64'd1);
    e = exp_q.pop_front();
    chk("imem_addr", imem_addr, e.pc);
    imem_rvalid = 1'b1; imem_rdata = ins.raw; run_en = ins.run_keep;
    dec_illegal = ins.ill; dec_load = ins.ld; dec_store = ins.st; dec_branch = ins.br;
    dec_jal = ins.jl; dec_jalr = ins.jr; dec_wb = ins.wb; dec_mem_len = ins.len;
    imm = ins.imm; rs1_val = ins.rs1; alu_result = ins.alu; br_taken = ins.taken;
    start_ir = instret;
    cyc = 1; memc = 0; aluc = 0; mseen = 0; leak = 0; rdy_cyc = -1; wr_cyc = -1;
    wr = 1'b0; we = 1'b0; sel = 2'd0; be = 8'h00; daddr = 64'd0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (instret != start_ir || halt) break;
      cyc++;
      aluc += int'(alu_en);
      sel = wb_sel;
      if (reg_wr_en) begin
        wr = 1'b1;
        wr_cyc = cyc;
      end
      if (dmem_req) begin
        memc++; mseen++;
        be = dmem_be; we = dmem_we; daddr = dmem_addr;
        dmem_ready = (mseen == ins.wait_n + 1);
        if (dmem_ready) rdy_cyc = cyc;
      end else begin
        dmem_ready = 1'b0;
        if (dmem_be != 8'h00) leak++;
      end
    end
    dmem_ready = 1'b0;
    chk("instr_q", 64'(instr_q), 64'(ins.raw));
    chk("cycles", 64'(cyc), 64'(e.cyc));
    chk("alu_en_pulses", 64'(aluc), 64'(e.aluc));
    chk("reg_wr_en", 64'(wr), 64'(e.wr));
    chk("wb_sel", 64'(sel), 64'(e.sel));
    chk("dmem_req_cycles", 64'(memc), 64'(e.memc));
    chk("dmem_be_idle_zero", 64'(leak), 64'd0);
    chk("halt", 64'(halt), 64'(e.halt));
    chk("trap_cause", 64'(trap_cause), 64'(e.cause));
    if (e.memc != 0) begin
      chk("dmem_be", 64'(be), 64'(e.be));
      chk("dmem_we", 64'(we), 64'(e.we));
      chk("dmem_addr", daddr, e.daddr);
    end
    if (ins.ld && rdy_cyc >= 0) chk("wr_after_ready", 64'(wr_cyc), 64'(rdy_cyc + 1));
  endtask

  initial begin
    ins_t ins;
    exp_t e;
    int   idle_req;
    run_en = 1'b1;
    do_reset();

    // Two addi back to back: 4 cycles each, instret reaches 2 after 8 cycles.
    ins = blank(32'h0010_0093); ins.wb = 1'b1;
    exp_q.push_back(mkexp(64'h8000_0000, 1'b1, 2'd0, 4)); run_instr(ins);
    exp_q.push_back(mkexp(64'h8000_0004, 1'b1, 2'd0, 4)); run_instr(ins);
    chk("instret_after_2", instret, 64'd2);

    ins = blank(32'h0080_006f); ins.jl = 1'b1; ins.wb = 1'b1; ins.imm = 64'd8;
    exp_q.push_back(mkexp(64'h8000_0008, 1'b1, 2'd2, 4)); run_instr(ins);

    // beq taken backwards by 8, then jal forward, then beq not taken.
    ins = blank(32'hfe00_0ce3); ins.br = 1'b1; ins.taken = 1'b1; ins.imm = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_q.push_back(mkexp(64'h8000_0010, 1'b0, 2'd0, 4)); run_instr(ins);
    ins = blank(32'h0080_006f); ins.jl = 1'b1; ins.wb = 1'b1; ins.imm = 64'd8;
    exp_q.push_back(mkexp(64'h8000_0008, 1'b1, 2'd2, 4)); run_instr(ins);
    ins = blank(32'hfe00_0ce3); ins.br = 1'b1; ins.taken = 1'b0; ins.imm = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_q.push_back(mkexp(64'h8000_0010, 1'b0, 2'd0, 4)); run_instr(ins);

    // lw from 0x1004 with three wait cycles.
    ins = blank(32'h0040_2083); ins.ld = 1'b1; ins.wb = 1'b1; ins.len = 4'd4; ins.alu = 64'h1004; ins.wait_n = 3;
    e = mkexp(64'h8000_0014, 1'b1, 2'd1, 8); e.memc = 4; e.be = 8'hF0; e.daddr = 64'h1004;
    exp_q.push_back(e); run_instr(ins);

    // sd to 0x2008, zero-wait.
    ins = blank(32'h0010_3423); ins.st = 1'b1; ins.len = 4'd8; ins.alu = 64'h2008;
    e = mkexp(64'h8000_0018, 1'b0, 2'd0, 5); e.memc = 1; e.be = 8'hFF; e.we = 1'b1; e.daddr = 64'h2008;
    exp_q.push_back(e); run_instr(ins);

    // run_en drops together with imem_rvalid: instruction retires, FSM parks in IDLE.
    ins = blank(32'h0010_0093); ins.wb = 1'b1; ins.run_keep = 1'b0;
    exp_q.push_back(mkexp(64'h8000_001c, 1'b1, 2'd0, 4)); run_instr(ins);
    idle_req = 0;
    repeat (3) begin
      @(negedge clk);
      idle_req += int'(imem_req);
    end
    chk("idle_no_fetch", 64'(idle_req), 64'd0);
    chk("idle_pc", pc, 64'h8000_0020);
    run_en = 1'b1;

    // sh to 0x1001 traps on data misalignment; trap is sticky and quiet.
    ins = blank(32'h0010_10a3); ins.st = 1'b1; ins.len = 4'd2; ins.alu = 64'h1001;
    e = mkexp(64'h8000_0020, 1'b0, 2'd0, 3); e.halt = 1'b1; e.cause = 2'd2;
    exp_q.push_back(e); run_instr(ins);
    repeat (5) @(negedge clk);
    chk("trap_sticky", 64'({halt, imem_req, dmem_req, alu_en, reg_wr_en}), 64'b10000);
    chk("trap_pc", pc, 64'h8000_0020);

    // Load that never completes: timeout after exactly DMEM_TIMEOUT MEM cycles.
    do_reset();
    ins = blank(32'h0000_2083); ins.ld = 1'b1; ins.wb = 1'b1; ins.len = 4'd4; ins.alu = 64'h1000; ins.wait_n = -1;
    e = mkexp(64'h8000_0000, 1'b0, 2'd0, 3 + DMEM_TIMEOUT); e.memc = DMEM_TIMEOUT; e.be = 8'h0F;
    e.daddr = 64'h1000; e.halt = 1'b1; e.cause = 2'd3;
    exp_q.push_back(e); run_instr(ins);
    chk("timeout_pc", pc, 64'h8000_0000);

    // Illegal opcode traps from DECODE without an execute strobe.
    do_reset();
    ins = blank(32'hFFFF_FFFF); ins.ill = 1'b1;
    e = mkexp(64'h8000_0000, 1'b0, 2'd0, 2); e.aluc = 0; e.halt = 1'b1; e.cause = 2'd0;
    exp_q.push_back(e); run_instr(ins);

    // jalr to 0x1002 traps on a misaligned jump target.
    do_reset();
    ins = blank(32'h0020_80e7); ins.jr = 1'b1; ins.wb = 1'b1; ins.rs1 = 64'h1000; ins.imm = 64'd2;
    e = mkexp(64'h8000_0000, 1'b0, 2'd0, 3); e.halt = 1'b1; e.cause = 2'd1;
    exp_q.push_back(e); run_instr(ins);
    chk("jalr_trap_pc", pc, 64'h8000_0000);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
